proc_program_feeder: RTL and testbench
======================================

Name: proc_program_feeder

Overview:
- Instruction-issuing counterpart to the 9-bit multi-cycle processor core.
- Fetches 9-bit words from a synchronous program memory, then drives the core's DIN/Run inputs one instruction at a time. Waits for the core's Done before issuing the next instruction.
- Supplies the MVI immediate word in the cycle after Run.
- Stops on a HALT opcode and flags a watchdog error if Done never arrives.

Parameters:
- ADDR_W, 5, program memory address width; PC wraps modulo 2^ADDR_W.
- TIMEOUT, 8, maximum WAIT cycles without Done before entering ERROR (must be at least 3).
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  level; starts or restarts the program at address 0.
- mem_addr  out  ADDR_W  program memory read address.
- mem_data  in  9  program memory read data; valid the cycle after mem_addr is presented.
- DIN  out  9  instruction/immediate word to the core.
- Run  out  1  one-cycle issue strobe to the core.
- Done  in  1  core completion flag (combinational from core, sampled at posedge).
- Busy  out  1  high in FETCH/LOAD/ISSUE/WAIT.
- Halted  out  1  high in HALT.
- Error  out  1  high in ERROR.
- instr_count  out  CNT_W  number of instructions completed.

Behaviour:
- Encoding: [8:6] opcode, [5:3] X, [2:0] Y. Opcodes: MV=000, MVI=001, ADD=010, SUB=011, HALT=111. Opcodes 100–110 are issued to the core like any other word.
- Internal state: PC (ADDR_W), holding register IRH (9), state, watchdog counter wd (sized for TIMEOUT).
- Reset, asynchronous: state=IDLE, PC=0, IRH=0, wd=0, instr_count=0. Outputs: Run=0, DIN=0, mem_addr=0, Busy=0, Halted=0, Error=0.
- IDLE: Start=1 → PC=0, instr_count=0, go to FETCH.
- FETCH: mem_addr=PC → LOAD.
- LOAD: mem_addr=PC; IRH<=mem_data. If mem_data[8:6]=111, go to HALT (nothing issued); otherwise go to ISSUE.
- ISSUE: DIN=IRH, Run=1 for exactly this cycle, mem_addr=PC+1 (wrapping), wd<=0 → WAIT.
- WAIT:
  - Run=0, mem_addr=PC+1.
  - DIN=mem_data if IRH[8:6]=001 (immediate word), else DIN=0.
  - Done=1: instr_count++ (wraps); PC<=PC+2 if MVI, else PC+1 (mod 2^ADDR_W); go to FETCH.
  - Done=0: wd++; when wd reaches TIMEOUT-1 with Done still 0, go to ERROR.
- HALT: Halted=1. Start=1 → PC=0, instr_count=0, go to FETCH.
- ERROR: Error=1, sticky until Resetn. Start is ignored.
- Start is ignored in FETCH/LOAD/ISSUE/WAIT.
- Done is ignored outside WAIT.
- Run is never high in two consecutive cycles. This is required because the core's IR loads on every Run-high edge.
- Latency from FETCH entry to next FETCH: MV/MVI 4 cycles; ADD/SUB 6 cycles (core Done in the 3rd WAIT cycle).
- Reset asserted mid-instruction returns to IDLE immediately; the core is reset by the same Resetn.
- All outputs are decoded from state and registers: no combinational path from Done to Run.

Test Plan:
- MVI sequence: memory [0]=040 (MVI R0), [1]=005, [2]=1C0 (HALT); Start pulse → Run high once with DIN=040; next cycle DIN=005; core Done; HALT reached with Halted=1, instr_count=1, PC=2; core R0=5.
- ADD program: MVI R0,3; MVI R1,4; ADD R0,R1 (081); HALT → three Run pulses, ADD's Done arrives 3 cycles after its Run, instr_count=3, core R0=7.
- Timeout: stub core never asserts Done after Run → Error=1 exactly TIMEOUT cycles after the Run cycle; Run stays 0 afterwards; Start ignored.
- Wrap: ADDR_W=2, memory [3]=040 (MVI) with immediate at [0], preceded by MV instructions → immediate fetched from address 0 and PC wraps to 1.
- Restart from HALT: after Halted=1, Start=1 → instr_count clears to 0 and Run is reissued with memory[0].
- Reset mid-WAIT of an ADD: Resetn low → Busy=0, Run=0, DIN=0, instr_count=0 asynchronously; after release, state stays IDLE until Start.

Source files
------------

// File: rtl/proc_program_feeder.sv
// -----------------------------------------------------------------------------
// proc_program_feeder
//
// Issues instructions to the 9-bit multi-cycle processor core. It reads words
// from a synchronous program memory and presents them on DIN with a one-cycle
// Run strobe. It then waits for the core's Done before fetching the next word.
// For MVI, the immediate word follows on DIN in the cycle after Run. A HALT
// opcode stops the program. A missing Done trips a watchdog that parks the
// block in a sticky ERROR state.
//
// Ports
//   Clock        in   rising-edge system clock
//   Resetn       in   asynchronous active-low reset (shared with the core)
//   Start        in   level; (re)starts the program at address 0 from IDLE/HALT
//   mem_addr     out  program memory read address
//   mem_data     in   program memory read data, valid the cycle after mem_addr
//   DIN          out  instruction / immediate word to the core
//   Run          out  one-cycle issue strobe to the core
//   Done         in   core completion flag, only looked at while waiting
//   Busy         out  high while fetching, loading, issuing or waiting
//   Halted       out  high after a HALT opcode was fetched
//   Error        out  high after a watchdog timeout, until reset
//   instr_count  out  number of instructions the core has completed
// -----------------------------------------------------------------------------
module proc_program_feeder #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_data,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  // The watchdog only has to count 0 .. TIMEOUT-1.
  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [8:0]        r_irh;
  logic [WD_W-1:0]   r_wd;
  logic [CNT_W-1:0]  r_instr_count;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_is_mvi;

  // PC arithmetic wraps naturally at the address width.
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_is_mvi  = (r_irh[8:6] == OP_MVI);
  // An MVI consumes its immediate word as well, so it skips one extra address.
  assign w_pc_next = w_is_mvi ? (r_pc + ADDR_W'(2)) : w_pc_inc;

  assign instr_count = r_instr_count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever order they appear in.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode. Outputs depend only on state, registers and
  // mem_data, so Done never reaches Run combinationally.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    mem_addr     = r_pc;
    DIN          = '0;
    Run          = 1'b0;
    Busy         = 1'b0;
    Halted       = 1'b0;
    Error        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (Start) w_next_state = S_FETCH;
      end

      S_FETCH: begin
        Busy         = 1'b1;
        w_next_state = S_LOAD;
      end

      // A HALT word is detected straight from memory and is never issued.
      S_LOAD: begin
        Busy         = 1'b1;
        w_next_state = (mem_data[8:6] == OP_HALT) ? S_HALT : S_ISSUE;
      end

      // Address PC+1 is presented now, so a possible immediate word is on
      // mem_data during the first WAIT cycle.
      S_ISSUE: begin
        Busy         = 1'b1;
        Run          = 1'b1;
        DIN          = r_irh;
        mem_addr     = w_pc_inc;
        w_next_state = S_WAIT;
      end

      S_WAIT: begin
        Busy     = 1'b1;
        mem_addr = w_pc_inc;
        if (w_is_mvi) DIN = mem_data;
        if (Done) begin
          w_next_state = S_FETCH;
        end else if (r_wd == WD_LAST) begin
          w_next_state = S_ERROR;
        end
      end

      S_HALT: begin
        Halted = 1'b1;
        if (Start) w_next_state = S_FETCH;
      end

      // Sticky until reset. Start is deliberately not decoded here.
      S_ERROR: begin
        Error = 1'b1;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers: PC, instruction holding register, watchdog, counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc          <= '0;
      r_irh         <= '0;
      r_wd          <= '0;
      r_instr_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            r_pc          <= '0;
            r_instr_count <= '0;
          end
        end
        S_LOAD: begin
          r_irh <= mem_data;
        end
        S_ISSUE: begin
          r_wd <= '0;
        end
        S_WAIT: begin
          if (Done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
            r_pc          <= w_pc_next;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_program_feeder.sv
`timescale 1ns/1ps
module tb_proc_program_feeder;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic [8:0] din;       // word expected on DIN while Run is high
    logic [8:0] wait_din;  // word expected on DIN in the following cycle
  } exp_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Resetn;
  int   cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- unit 1: default sizes, driving a core model ----------------
  logic       Start1, Run1, Done1, Busy1, Halted1, Error1;
  logic [4:0] mem_addr1;
  logic [8:0] mem_data1, DIN1;
  logic [7:0] count1;
  logic [8:0] mem1 [32];

  proc_program_feeder #(.ADDR_W(5), .TIMEOUT(TIMEOUT), .CNT_W(8)) u1 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start1),
    .mem_addr(mem_addr1), .mem_data(mem_data1),
    .DIN(DIN1), .Run(Run1), .Done(Done1),
    .Busy(Busy1), .Halted(Halted1), .Error(Error1), .instr_count(count1)
  );

  always @(posedge Clock) mem_data1 <= mem1[mem_addr1];

  // Core model: MV/MVI complete in the first cycle after Run, ADD/SUB in the
  // third. done_en=0 turns it into a core that never answers.
  logic       done_en;
  logic [8:0] c_ir;
  logic [1:0] c_step;
  logic [8:0] c_r [8];
  logic [2:0] c_op;
  assign c_op = c_ir[8:6];

  always_comb begin
    Done1 = 1'b0;
    if (done_en && c_step != 2'd0)
      Done1 = (c_op == 3'b010 || c_op == 3'b011) ? (c_step == 2'd3) : (c_step == 2'd1);
  end

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      c_ir   <= '0;
      c_step <= '0;
      for (int i = 0; i < 8; i++) c_r[i] <= '0;
    end else if (Run1) begin
      c_ir   <= DIN1;
      c_step <= 2'd1;
    end else if (c_step != 2'd0) begin
      if (Done1) begin
        c_step <= 2'd0;
        case (c_op)
          3'b000:  c_r[c_ir[5:3]] <= c_r[c_ir[2:0]];
          3'b001:  c_r[c_ir[5:3]] <= DIN1;
          3'b010:  c_r[c_ir[5:3]] <= c_r[c_ir[5:3]] + c_r[c_ir[2:0]];
          3'b011:  c_r[c_ir[5:3]] <= c_r[c_ir[5:3]] - c_r[c_ir[2:0]];
          default: ;
        endcase
      end else if (c_step != 2'd3) begin
        c_step <= c_step + 2'd1;
      end
    end
  end

  // ---------------- unit 2: 2-bit PC, core always done ----------------
  logic       Start2, Run2, Done2, Busy2, Halted2, Error2;
  logic [1:0] mem_addr2;
  logic [8:0] mem_data2, DIN2;
  logic [7:0] count2;
  logic [8:0] mem2 [4];
  assign Done2 = 1'b1;

  proc_program_feeder #(.ADDR_W(2), .TIMEOUT(TIMEOUT), .CNT_W(8)) u2 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start2),
    .mem_addr(mem_addr2), .mem_data(mem_data2),
    .DIN(DIN2), .Run(Run2), .Done(Done2),
    .Busy(Busy2), .Halted(Halted2), .Error(Error2), .instr_count(count2)
  );

  always @(posedge Clock) mem_data2 <= mem2[mem_addr2];

  // ---------------- scoreboards and monitors ----------------
  exp_t       q1[$], q2[$];
  bit         pend1, pend2;
  logic [8:0] pend_val1, pend_val2;
  int         run_cnt1 = 0, run_cnt2 = 0, last_run1 = 0;

  always @(negedge Clock) begin
    exp_t e;
    if (!Resetn) begin
      pend1 = 1'b0;
    end else if (pend1) begin
      pend1 = 1'b0;
      check("u1_run_low_after_issue", Run1, 1'b0);
      check("u1_wait_din", DIN1, pend_val1);
    end else if (Run1) begin
      run_cnt1++;
      last_run1 = cyc;
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL u1_unexpected_run: got DIN %0h expected no issue (t=%0t)", DIN1, $time);
      end else begin
        e = q1.pop_front();
        check("u1_issue_din", DIN1, e.din);
        pend1     = 1'b1;
        pend_val1 = e.wait_din;
      end
    end
  end

  always @(negedge Clock) begin
    exp_t e;
    if (!Resetn) begin
      pend2 = 1'b0;
    end else if (pend2) begin
      pend2 = 1'b0;
      check("u2_run_low_after_issue", Run2, 1'b0);
      check("u2_wait_din", DIN2, pend_val2);
    end else if (Run2) begin
      run_cnt2++;
      if (q2.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL u2_unexpected_run: got DIN %0h expected no issue (t=%0t)", DIN2, $time);
      end else begin
        e = q2.pop_front();
        check("u2_issue_din", DIN2, e.din);
        pend2     = 1'b1;
        pend_val2 = e.wait_din;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    Resetn  = 1'b0;
    Start1  = 1'b0;
    Start2  = 1'b0;
    done_en = 1'b1;
    for (int i = 0; i < 32; i++) mem1[i] = 9'h1C0;
    for (int i = 0; i < 4; i++)  mem2[i] = 9'h1C0;

    repeat (3) @(negedge Clock);
    check("reset_busy",     Busy1,     1'b0);
    check("reset_run",      Run1,      1'b0);
    check("reset_din",      DIN1,      9'h000);
    check("reset_mem_addr", mem_addr1, 5'd0);
    check("reset_count",    count1,    8'd0);
    check("reset_halted",   Halted1,   1'b0);
    check("reset_error",    Error1,    1'b0);
    Resetn = 1'b1;
    @(negedge Clock);

    // Wrap: MVI at address 3 takes its immediate from address 0, then PC
    // wraps to 1. Address 2 becomes HALT on the second pass.
    mem2[0] = 9'h00A;  mem2[1] = 9'h013;  mem2[2] = 9'h01C;  mem2[3] = 9'h040;
    q2.push_back('{9'h00A, 9'h000});
    q2.push_back('{9'h013, 9'h000});
    q2.push_back('{9'h01C, 9'h000});
    q2.push_back('{9'h040, 9'h00A});
    q2.push_back('{9'h013, 9'h000});
    Start2 = 1'b1;
    @(negedge Clock);
    Start2 = 1'b0;
    for (int i = 0; i < 200 && run_cnt2 < 5; i++) @(negedge Clock);
    check("u2_issue_count", run_cnt2, 5);
    mem2[2] = 9'h1C0;
    for (int i = 0; i < 50 && !Halted2; i++) @(negedge Clock);
    check("u2_halted",        Halted2,   1'b1);
    check("u2_halt_pc",       mem_addr2, 2'd2);
    check("u2_count",         count2,    8'd5);
    check("u2_queue_drained", q2.size(), 0);

    // MVI R0,5 then HALT.
    mem1[0] = 9'h040;  mem1[1] = 9'h005;  mem1[2] = 9'h1C0;
    q1.push_back('{9'h040, 9'h005});
    Start1 = 1'b1;
    @(negedge Clock);
    Start1 = 1'b0;
    for (int i = 0; i < 100 && !Halted1; i++) @(negedge Clock);
    check("mvi_halted",   Halted1,   1'b1);
    check("mvi_busy",     Busy1,     1'b0);
    check("mvi_count",    count1,    8'd1);
    check("mvi_halt_pc",  mem_addr1, 5'd2);
    check("mvi_core_r0",  c_r[0],    9'd5);

    // Restart from HALT with MVI R0,3; MVI R1,4; ADD R0,R1; HALT.
    mem1[0] = 9'h040;  mem1[1] = 9'h003;  mem1[2] = 9'h048;
    mem1[3] = 9'h004;  mem1[4] = 9'h081;  mem1[5] = 9'h1C0;
    q1.push_back('{9'h040, 9'h003});
    q1.push_back('{9'h048, 9'h004});
    q1.push_back('{9'h081, 9'h000});
    Start1 = 1'b1;
    @(negedge Clock);
    Start1 = 1'b0;
    check("restart_count_clear", count1,  8'd0);
    check("restart_busy",        Busy1,   1'b1);
    check("restart_not_halted",  Halted1, 1'b0);
    for (int i = 0; i < 100 && !Halted1; i++) @(negedge Clock);
    check("add_halted",  Halted1, 1'b1);
    // ISSUE, three WAIT cycles, FETCH, LOAD, then HALT.
    check("add_run_to_halt_cycles", cyc - last_run1, 6);
    check("add_count",   count1,  8'd3);
    check("add_core_r0", c_r[0],  9'd7);
    check("add_halt_pc", mem_addr1, 5'd5);

    // Timeout: the core never answers.
    done_en = 1'b0;
    mem1[0] = 9'h081;
    q1.push_back('{9'h081, 9'h000});
    Start1 = 1'b1;
    @(negedge Clock);
    Start1 = 1'b0;
    for (int i = 0; i < 100 && !Error1; i++) @(negedge Clock);
    check("timeout_error", Error1, 1'b1);
    // TIMEOUT WAIT cycles follow the Run cycle before ERROR is entered.
    check("timeout_cycles", cyc - last_run1, TIMEOUT + 1);
    Start1 = 1'b1;
    @(negedge Clock);
    Start1 = 1'b0;
    repeat (4) @(negedge Clock);
    check("error_sticky",       Error1,    1'b1);
    check("error_not_busy",     Busy1,     1'b0);
    check("timeout_queue_empty", q1.size(), 0);

    // Reset clears ERROR.
    #2 Resetn = 1'b0;
    #1 check("reset_clears_error", Error1, 1'b0);
    @(negedge Clock);
    Resetn  = 1'b1;
    done_en = 1'b1;

    // Reset in the middle of an ADD's WAIT.
    mem1[0] = 9'h040;  mem1[1] = 9'h003;  mem1[2] = 9'h081;  mem1[3] = 9'h1C0;
    q1.push_back('{9'h040, 9'h003});
    q1.push_back('{9'h081, 9'h000});
    base = run_cnt1;
    Start1 = 1'b1;
    @(negedge Clock);
    Start1 = 1'b0;
    for (int i = 0; i < 100 && run_cnt1 < base + 2; i++) @(negedge Clock);
    @(negedge Clock);
    check("midwait_count_before", count1, 8'd1);
    check("midwait_busy_before",  Busy1,  1'b1);
    #2 Resetn = 1'b0;
    #1;
    check("midwait_reset_busy",  Busy1,     1'b0);
    check("midwait_reset_run",   Run1,      1'b0);
    check("midwait_reset_din",   DIN1,      9'h000);
    check("midwait_reset_count", count1,    8'd0);
    check("midwait_reset_addr",  mem_addr1, 5'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (4) @(negedge Clock);
    check("idle_after_reset_busy",   Busy1,     1'b0);
    check("idle_after_reset_halted", Halted1,   1'b0);
    check("idle_after_reset_addr",   mem_addr1, 5'd0);
    check("idle_after_reset_queue",  q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
